logic_gate_unit: RTL and testbench

Parametrised, registered successor to the two-input basic-gate block. Applies one of eight bitwise gate functions to WIDTH-bit operands and returns the result through a valid/ready output register. A built-in sweep mode walks every operand combination (truth-table generation) on its own, so benches and board demos can exercise a gate without external stimulus.

---
 rtl/logic_gate_pkg.sv | 26 ++
 rtl/logic_gate_core.sv | 27 ++
 rtl/logic_gate_unit.sv | 149 ++++++++++++++
 tb/tb_logic_gate_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/logic_gate_pkg.sv
// Shared types and sweep helpers for the registered logic gate unit.
package logic_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOT  = 3'd6,
        OP_BUF  = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // Number of operand combinations walked by a sweep of sw bits per operand.
    function automatic int unsigned sweep_count(input int unsigned sw);
        return 32'd1 << (2 * sw);
    endfunction

endpackage

// File: rtl/logic_gate_core.sv
// Combinational bitwise gate: eight functions over WIDTH-bit operands.
module logic_gate_core
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  op_e              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_XNOR: y = ~(a ^ b);
            OP_NOT:  y = ~a;
            OP_BUF:  y = a;
        endcase
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Registered gate unit with valid/ready output and self-driven truth-table sweep.
// Optional LOGIC_GATE_PARITY_EN adds a registered out_parity of y.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int SWEEP_W = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 start,
    output logic [WIDTH-1:0]     y,
    output logic [2*SWEEP_W-1:0] out_idx,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
`ifdef LOGIC_GATE_PARITY_EN
    output logic                 out_parity,
`endif
    output logic                 done
);

    localparam int CW = 2 * SWEEP_W;
    localparam int unsigned N_SWEEP = sweep_count(SWEEP_W);
    localparam logic [CW-1:0] CNT_MAX = CW'(N_SWEEP - 1);

    state_e            state_q;
    op_e               op_q;
    logic [CW-1:0]     cnt_q;
    logic [CW-1:0]     cnt_d;
    logic [WIDTH-1:0]  y_q;
    logic [WIDTH-1:0]  y_d;
    logic [CW-1:0]     idx_q;
    logic              valid_q;
    logic              done_q;

    logic              slot_free;
    logic              load;
    op_e               core_op;
    logic [WIDTH-1:0]  core_a;
    logic [WIDTH-1:0]  core_b;

    assign slot_free = !valid_q || out_ready;
    assign in_ready  = (state_q == IDLE) && slot_free && !start;
    assign cnt_d     = cnt_q + 1'b1;

    always_comb begin
        load = 1'b0;
        unique case (state_q)
            IDLE:    load = in_valid && in_ready;
            SWEEP:   load = slot_free;
            default: load = 1'b0;
        endcase
    end

    // Sweep operands come from the counter halves, zero-extended to WIDTH.
    always_comb begin
        if (state_q == IDLE) begin
            core_op = op_e'(op);
            core_a  = a;
            core_b  = b;
        end else begin
            core_op = op_q;
            core_a  = WIDTH'(cnt_q[CW-1:SWEEP_W]);
            core_b  = WIDTH'(cnt_q[SWEEP_W-1:0]);
        end
    end

    logic_gate_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .op (core_op),
        .a  (core_a),
        .b  (core_b),
        .y  (y_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= OP_AND;
            cnt_q   <= '0;
            y_q     <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (load) begin
                y_q     <= y_d;
                idx_q   <= (state_q == SWEEP) ? cnt_q : '0;
                valid_q <= 1'b1;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        op_q    <= op_e'(op);
                        cnt_q   <= '0;
                        state_q <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (slot_free) begin
                        if (cnt_q == CNT_MAX) begin
                            state_q <= DRAIN;
                        end else begin
                            cnt_q <= cnt_d;
                        end
                    end
                end
                DRAIN: begin
                    if (valid_q && out_ready) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef LOGIC_GATE_PARITY_EN
    logic par_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (load) begin
            par_q <= ^y_d;
        end
    end

    assign out_parity = par_q;
`endif

    assign y         = y_q;
    assign out_idx   = idx_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed self-checking bench for logic_gate_unit (WIDTH=4, SWEEP_W=1).
module tb_logic_gate_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic       in_ready;
    logic       start;
    logic [3:0] y;
    logic [1:0] out_idx;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
`ifdef LOGIC_GATE_PARITY_EN
    logic       out_parity;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    logic_gate_unit #(
        .WIDTH   (4),
        .SWEEP_W (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .op         (op),
        .a          (a),
        .b          (b),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .start      (start),
        .y          (y),
        .out_idx    (out_idx),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
`ifdef LOGIC_GATE_PARITY_EN
        .out_parity (out_parity),
`endif
        .done       (done)
    );

    typedef struct {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp_y;
        logic       exp_par;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] xor_exp[4];
        logic [3:0] nand_exp[4];

        vecs[0] = '{3'd0, 4'b1100, 4'b1010, 4'b1000, 1'b1};
        vecs[1] = '{3'd1, 4'b1100, 4'b1010, 4'b1110, 1'b1};
        vecs[2] = '{3'd2, 4'b1100, 4'b1010, 4'b0111, 1'b1};
        vecs[3] = '{3'd3, 4'b1100, 4'b1010, 4'b0001, 1'b1};
        vecs[4] = '{3'd4, 4'b1100, 4'b1010, 4'b0110, 1'b0};
        vecs[5] = '{3'd5, 4'b1100, 4'b1010, 4'b1001, 1'b0};
        vecs[6] = '{3'd6, 4'b0101, 4'b1111, 4'b1010, 1'b0};
        vecs[7] = '{3'd7, 4'b0101, 4'b1111, 4'b0101, 1'b0};
        vecs[8] = '{3'd1, 4'b0101, 4'b0011, 4'b0111, 1'b1};
        xor_exp  = '{4'b0000, 4'b0001, 4'b0001, 4'b0000};
        nand_exp = '{4'b1111, 4'b1111, 4'b1111, 4'b1110};

        rst = 1'b1; op = '0; a = '0; b = '0;
        in_valid = 1'b0; start = 1'b0; out_ready = 1'b1;
        step();
        step();
        rst = 1'b0;
        check("rst_y", 32'(y), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_idx", 32'(out_idx), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h1);

        // Back-to-back direct operands under continuous out_ready.
        for (int i = 0; i < 9; i++) begin
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            in_valid = 1'b1;
            #1;
            check("vec_in_ready", 32'(in_ready), 32'h1);
            step();
            check($sformatf("vec%0d_y", i), 32'(y), 32'(vecs[i].exp_y));
            check("vec_valid", 32'(out_valid), 32'h1);
            check("vec_idx", 32'(out_idx), 32'h0);
`ifdef LOGIC_GATE_PARITY_EN
            check($sformatf("vec%0d_par", i), 32'(out_parity),
                  32'(vecs[i].exp_par));
`endif
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", 32'(out_valid), 32'h0);

        // NOT with backpressure on the following operand.
        op = 3'd6; a = 4'b0101; in_valid = 1'b1;
        step();
        check("not_y", 32'(y), 32'b1010);
        out_ready = 1'b0; op = 3'd7; a = 4'b0011;
        #1;
        check("bp_in_ready", 32'(in_ready), 32'h0);
        step();
        check("bp_hold_y", 32'(y), 32'b1010);
        check("bp_hold_valid", 32'(out_valid), 32'h1);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(in_ready), 32'h1);
        step();
        check("bp_second_y", 32'(y), 32'b0011);
        in_valid = 1'b0;
        step();
        check("bp_drain", 32'(out_valid), 32'h0);

        // XOR sweep, free-running.
        op = 3'd4; start = 1'b1;
        step();
        start = 1'b0;
        check("xs_busy0", 32'(busy), 32'h1);
        check("xs_valid0", 32'(out_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("xs_y%0d", i), 32'(y), 32'(xor_exp[i]));
            check($sformatf("xs_idx%0d", i), 32'(out_idx), 32'(i));
            check("xs_valid", 32'(out_valid), 32'h1);
            check("xs_busy", 32'(busy), 32'h1);
            check("xs_in_ready", 32'(in_ready), 32'h0);
            check("xs_no_done", 32'(done), 32'h0);
        end
        step();
        check("xs_done", 32'(done), 32'h1);
        check("xs_end_valid", 32'(out_valid), 32'h0);
        check("xs_end_busy", 32'(busy), 32'h0);
        step();
        check("xs_done_once", 32'(done), 32'h0);

        // NAND sweep stalled at idx 2 with a stray start.
        op = 3'd2; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("ns_y%0d", i), 32'(y), 32'(nand_exp[i]));
        end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start = (i == 0);
            op = 3'd0;
            step();
            check("stall_y", 32'(y), 32'(nand_exp[2]));
            check("stall_idx", 32'(out_idx), 32'h2);
            check("stall_valid", 32'(out_valid), 32'h1);
            check("stall_busy", 32'(busy), 32'h1);
        end
        start = 1'b0; out_ready = 1'b1;
        step();
        check("resume_idx", 32'(out_idx), 32'h3);
        check("resume_y", 32'(y), 32'(nand_exp[3]));
        step();
        check("ns_done", 32'(done), 32'h1);
        step();

        // Reset in the middle of a sweep.
        op = 3'd4; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("pre_rst_idx", 32'(out_idx), 32'h2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_valid", 32'(out_valid), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_y", 32'(y), 32'h0);
        check("mid_rst_idle", 32'(in_ready), 32'h1);

        // start beats a simultaneous in_valid.
        op = 3'd0; a = 4'b1111; b = 4'b1111;
        in_valid = 1'b1; start = 1'b1;
        #1;
        check("sim_in_ready", 32'(in_ready), 32'h0);
        step();
        in_valid = 1'b0; start = 1'b0;
        check("sim_busy", 32'(busy), 32'h1);
        check("sim_not_accepted", 32'(out_valid), 32'h0);
        step();
        check("sim_sweep_y0", 32'(y), 32'h0);
        check("sim_sweep_idx0", 32'(out_idx), 32'h0);
        for (int i = 0; i < 4; i++) step();
        check("sim_done", 32'(done), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
